// File: rtl/cartoon_pkg.sv
// ---------------------------------------------------------------------------
// cartoon_pkg
// Shared types and constants for the cartoonifier write path.
//   state_t        : write sequencer states
//   PIX_PER_BURST  : pixels per ping-pong bank (one 32-bit word each)
//   FRAME_W/H      : frame geometry, default pixel count is FRAME_W*FRAME_H
//   BYTES_PER_WORD : Avalon byte-address step per pixel word
// ---------------------------------------------------------------------------
package cartoon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BANK = 2'd1,
      WRITE     = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int PIX_PER_BURST  = 6;
   localparam int FRAME_W        = 640;
   localparam int FRAME_H        = 480;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/write_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// write_burst_ctrl_if
// Avalon-MM write-only master bundle between the burst controller and SDRAM.
//   master_write       : write strobe (master -> slave)
//   master_address     : byte address  (master -> slave)
//   master_waitrequest : stall         (slave  -> master)
// ---------------------------------------------------------------------------
interface write_burst_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              master_write;
   logic [ADDR_W-1:0] master_address;
   logic              master_waitrequest;

   modport master (
      output master_write,
      output master_address,
      input  master_waitrequest
   );

   modport slave (
      input  master_write,
      input  master_address,
      output master_waitrequest
   );
endinterface

// File: rtl/write_burst_ctrl_bank_tracker.sv
// ---------------------------------------------------------------------------
// bank_tracker
// Owns the ping-pong bank occupancy for the pixel write buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : accepted frame start; empties both banks, clears error
//   active        : a frame is in progress (WAIT_BANK or WRITE)
//   bank_loaded   : producer finished filling fill_bank
//   drain_release : last word of drain_bank accepted by the bus
//   bank_full     : per-bank occupancy
//   fill_bank     : bank the producer writes next
//   drain_bank    : bank being written out
//   fill_ready    : fill_bank is empty and a frame is active
//   overflow_err  : sticky; bank_loaded seen while fill_ready was low
// ---------------------------------------------------------------------------
module bank_tracker (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       active,
   input  logic       bank_loaded,
   input  logic       drain_release,
   output logic [1:0] bank_full,
   output logic       fill_bank,
   output logic       drain_bank,
   output logic       fill_ready,
   output logic       overflow_err
);

   logic [1:0] bank_full_reg;
   logic [1:0] bank_full_next;
   logic       fill_bank_reg;
   logic       drain_bank_reg;
   logic       overflow_err_reg;
   logic       load_ok;
   logic       load_bad;

   assign fill_ready = active && !bank_full_reg[fill_bank_reg];
   assign load_ok    = bank_loaded && fill_ready;
   assign load_bad   = bank_loaded && active && !fill_ready;

   // A load and a drain release in the same cycle always hit different
   // banks (the fill bank is never the one being drained while full), so
   // each bank sees at most one of the two events.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         always_comb begin
            bank_full_next[gi] = bank_full_reg[gi];
            if (load_ok && (fill_bank_reg == gi[0]))
               bank_full_next[gi] = 1'b1;
            if (drain_release && (drain_bank_reg == gi[0]))
               bank_full_next[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_full_reg    <= 2'b00;
         fill_bank_reg    <= 1'b0;
         drain_bank_reg   <= 1'b0;
         overflow_err_reg <= 1'b0;
      end else if (clear) begin
         bank_full_reg    <= 2'b00;
         fill_bank_reg    <= 1'b0;
         drain_bank_reg   <= 1'b0;
         overflow_err_reg <= 1'b0;
      end else begin
         bank_full_reg <= bank_full_next;
         if (load_ok)
            fill_bank_reg <= !fill_bank_reg;
         if (drain_release)
            drain_bank_reg <= !drain_bank_reg;
         if (load_bad)
            overflow_err_reg <= 1'b1;
      end
   end

   assign bank_full    = bank_full_reg;
   assign fill_bank    = fill_bank_reg;
   assign drain_bank   = drain_bank_reg;
   assign overflow_err = overflow_err_reg;

endmodule

// File: rtl/write_burst_ctrl.sv
// ---------------------------------------------------------------------------
// write_burst_ctrl
// Scheduler and Avalon-MM write sequencer for the ping-pong pixel buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : pulse, begins a frame (only honoured in IDLE)
//   base_addr     : frame base byte address, sampled on accepted start
//   bank_loaded   : pulse, producer finished the current fill bank
//   fill_bank     : bank the producer must write
//   fill_ready    : fill bank empty and frame active
//   drain_bank    : bank being written to SDRAM
//   word_sel      : pixel index within drain_bank for the buffer mux
//   burst_done    : pulse, cycle after the last word of a bank is accepted
//   frame_done    : pulse, cycle after the last word of the frame is accepted
//   overflow_err  : sticky, bank_loaded while fill_ready was low
//   bus           : Avalon-MM write master (write/address/waitrequest)
// ---------------------------------------------------------------------------
module write_burst_ctrl
   import cartoon_pkg::*;
#(
   parameter int PIX_PER_BURST = cartoon_pkg::PIX_PER_BURST,
   parameter int TOTAL_PIXELS  = FRAME_W * FRAME_H,
   parameter int ADDR_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              bank_loaded,
   output logic              fill_bank,
   output logic              fill_ready,
   output logic              drain_bank,
   output logic [2:0]        word_sel,
   output logic              burst_done,
   output logic              frame_done,
   output logic              overflow_err,
   write_burst_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(TOTAL_PIXELS + 1);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        word_idx_reg;
   logic [CNT_W-1:0]  pix_cnt_reg;
   logic              burst_done_reg;
   logic [1:0]        bank_full;

   logic start_accept;
   logic active;
   logic accept;
   logic last_word;
   logic last_pix;
   logic drain_ready;

   assign start_accept = start && (state_reg == IDLE);
   assign active       = (state_reg == WAIT_BANK) || (state_reg == WRITE);
   assign accept       = (state_reg == WRITE) && !bus.master_waitrequest;
   assign last_word    = (word_idx_reg == 3'(PIX_PER_BURST - 1));
   assign last_pix     = (pix_cnt_reg == CNT_W'(TOTAL_PIXELS - 1));
   assign drain_ready  = bank_full[drain_bank];

   bank_tracker u_bank_tracker (
      .clk           (clk),
      .rst           (rst),
      .clear         (start_accept),
      .active        (active),
      .bank_loaded   (bank_loaded),
      .drain_release (accept && last_word),
      .bank_full     (bank_full),
      .fill_bank     (fill_bank),
      .drain_bank    (drain_bank),
      .fill_ready    (fill_ready),
      .overflow_err  (overflow_err)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (start) state_next = WAIT_BANK;
         WAIT_BANK: if (drain_ready) state_next = WRITE;
         WRITE:     if (accept && last_word)
                       state_next = last_pix ? DONE : WAIT_BANK;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Address / word / pixel counters. Everything holds while the bus stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg       <= '0;
         word_idx_reg   <= '0;
         pix_cnt_reg    <= '0;
         burst_done_reg <= 1'b0;
      end else begin
         burst_done_reg <= accept && last_word;
         if (start_accept) begin
            addr_reg     <= base_addr;
            pix_cnt_reg  <= '0;
            word_idx_reg <= '0;
         end else if ((state_reg == WAIT_BANK) && drain_ready) begin
            word_idx_reg <= '0;
         end else if (accept) begin
            addr_reg     <= addr_reg + ADDR_W'(BYTES_PER_WORD);  // wraps freely
            pix_cnt_reg  <= pix_cnt_reg + 1'b1;
            // Park at 0 after the last word so word_sel stays in 0..5
            word_idx_reg <= last_word ? 3'd0 : word_idx_reg + 3'd1;
         end
      end
   end

   // Output logic
   always_comb begin
      bus.master_write   = (state_reg == WRITE);
      bus.master_address = (state_reg == WRITE) ? addr_reg : '0;
      word_sel           = word_idx_reg;
      frame_done         = (state_reg == DONE);
      burst_done         = burst_done_reg;
   end

endmodule

// File: tb/tb_write_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_write_burst_ctrl
// Scoreboard bench: stimulus pushes expected (address, word_sel) pairs per
// loaded bank; a negedge monitor pops and compares on every accepted write.
// ---------------------------------------------------------------------------
module tb_write_burst_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  sel;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic        bank_loaded;
   logic        fill_bank;
   logic        fill_ready;
   logic        drain_bank;
   logic [2:0]  word_sel;
   logic        burst_done;
   logic        frame_done;
   logic        overflow_err;

   write_burst_ctrl_if #(.ADDR_W(32)) bus ();

   write_burst_ctrl #(
      .PIX_PER_BURST (6),
      .TOTAL_PIXELS  (12),
      .ADDR_W        (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .bank_loaded  (bank_loaded),
      .fill_bank    (fill_bank),
      .fill_ready   (fill_ready),
      .drain_bank   (drain_bank),
      .word_sel     (word_sel),
      .burst_done   (burst_done),
      .frame_done   (frame_done),
      .overflow_err (overflow_err),
      .bus          (bus)
   );

   exp_t        exp_q[$];
   logic [31:0] exp_addr;
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   int          cyc       = 0;
   int          last_acc  = 0;
   int          burst_cnt = 0;
   int          frame_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("ok   %s: got %h", name, act);
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{addr: exp_addr, sel: 3'(i)});
         exp_addr = exp_addr + 32'd4;
      end
   endtask

   task automatic pulse_load();
      bank_loaded = 1'b1;
      step();
      bank_loaded = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] base);
      base_addr = base;
      start     = 1'b1;
      step();
      start     = 1'b0;
      exp_addr  = base;
   endtask

   task automatic wait_sel(input logic [2:0] s);
      int n = 0;
      while (!(bus.master_write && word_sel == s) && n < 100) begin
         step();
         n++;
      end
      check("wait_word_sel", 32'(n < 100), 32'd1);
   endtask

   task automatic wait_frame();
      int f0 = frame_cnt;
      int n  = 0;
      while (frame_cnt == f0 && n < 200) begin
         step();
         n++;
      end
      check("frame_done_seen", 32'(frame_cnt != f0), 32'd1);
      step();
      check("idle_after_frame_write", 32'(bus.master_write), 32'd0);
      check("idle_after_frame_fill_ready", 32'(fill_ready), 32'd0);
   endtask

   // Monitor: compares each accepted bus write against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.master_write && !bus.master_waitrequest) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", bus.master_address, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("write_addr", bus.master_address, e.addr);
               check("write_word_sel", 32'(word_sel), 32'(e.sel));
            end
            last_acc = cyc;
         end
         if (burst_done)
            burst_cnt++;
         if (frame_done) begin
            frame_cnt++;
            check("frame_done_latency", 32'(cyc - last_acc), 32'd1);
            check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
         end
      end
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      bank_loaded = 1'b0;
      bus.master_waitrequest = 1'b0;
      exp_addr    = '0;

      // Reset state
      step();
      step();
      check("rst_master_write", 32'(bus.master_write), 32'd0);
      check("rst_master_address", bus.master_address, 32'd0);
      check("rst_word_sel", 32'(word_sel), 32'd0);
      check("rst_fill_ready", 32'(fill_ready), 32'd0);
      check("rst_fill_drain_bank", {30'd0, fill_bank, drain_bank}, 32'd0);
      check("rst_pulses_err", {29'd0, burst_done, frame_done, overflow_err}, 32'd0);
      rst = 1'b0;
      step();

      // Frame 1: two loads, then an overflowing third load
      do_start(32'h0000_1000);
      check("f1_fill_ready_after_start", 32'(fill_ready), 32'd1);
      push_burst();
      bank_loaded = 1'b1;
      step();
      push_burst();
      step();
      bank_loaded = 1'b0;
      check("f1_fill_ready_both_full", 32'(fill_ready), 32'd0);
      check("f1_fill_bank_after_two", 32'(fill_bank), 32'd0);
      pulse_load();
      check("f1_overflow_set", 32'(overflow_err), 32'd1);
      check("f1_fill_ready_unchanged", 32'(fill_ready), 32'd0);
      check("f1_fill_bank_unchanged", 32'(fill_bank), 32'd0);
      check("f1_drain_bank", 32'(drain_bank), 32'd0);
      wait_frame();
      check("f1_bursts", 32'(burst_cnt), 32'd2);

      // Frame 2: load on the same cycle as the 6th accept of the other bank
      do_start(32'h0000_2000);
      check("f2_overflow_cleared", 32'(overflow_err), 32'd0);
      push_burst();
      pulse_load();
      wait_sel(3'd5);
      push_burst();
      pulse_load();
      check("f2_bubble_write_low", 32'(bus.master_write), 32'd0);
      check("f2_drain_bank_toggled", 32'(drain_bank), 32'd1);
      check("f2_fill_bank_toggled", 32'(fill_bank), 32'd0);
      check("f2_fill_ready_both_applied", 32'(fill_ready), 32'd1);
      step();
      check("f2_write_after_one_bubble", 32'(bus.master_write), 32'd1);
      check("f2_second_burst_addr", bus.master_address, 32'h0000_2018);
      wait_frame();

      // Frame 3: 3-cycle stall on word 2, ignored start during WRITE
      do_start(32'h0000_1000);
      push_burst();
      pulse_load();
      wait_sel(3'd2);
      bus.master_waitrequest = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("f3_stall_addr", bus.master_address, 32'h0000_1008);
         check("f3_stall_word_sel", 32'(word_sel), 32'd2);
         if (k == 1) begin
            base_addr = 32'h0000_9000;
            start     = 1'b1;
         end
         step();
         start = 1'b0;
      end
      bus.master_waitrequest = 1'b0;
      step();
      check("f3_one_increment_sel", 32'(word_sel), 32'd3);
      check("f3_one_increment_addr", bus.master_address, 32'h0000_100C);
      push_burst();
      pulse_load();
      wait_frame();

      // Frame 4: address wraps through zero
      do_start(32'hFFFF_FFF0);
      push_burst();
      bank_loaded = 1'b1;
      step();
      push_burst();
      step();
      bank_loaded = 1'b0;
      wait_frame();

      // Frame 5: reset during word 4, then a clean restart
      do_start(32'h0000_3000);
      push_burst();
      pulse_load();
      wait_sel(3'd4);
      rst = 1'b1;
      #1;
      check("rst_mid_write_low", 32'(bus.master_write), 32'd0);
      check("rst_mid_word_sel", 32'(word_sel), 32'd0);
      exp_q.delete();
      step();
      rst = 1'b0;
      step();
      check("post_rst_idle_write", 32'(bus.master_write), 32'd0);
      check("post_rst_fill_ready", 32'(fill_ready), 32'd0);
      do_start(32'h0000_4000);
      check("post_rst_fill_ready_start", 32'(fill_ready), 32'd1);
      push_burst();
      bank_loaded = 1'b1;
      step();
      push_burst();
      step();
      bank_loaded = 1'b0;
      step();
      check("post_rst_first_addr", bus.master_address, 32'h0000_4004);
      wait_frame();

      check("total_bursts", 32'(burst_cnt), 32'd10);
      check("total_frames", 32'(frame_cnt), 32'd5);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/write_burst_ctrl.md
Name: write_burst_ctrl

Overview:
- Scheduler and Avalon-MM write sequencer for the ping-pong pixel write buffer (two banks, 6 pixels per bank).
- Tracks which bank the filter pipeline is filling and which bank is draining to SDRAM.
- Generates word-aligned addresses from a frame base address; selects the drain word for the buffer mux.
- Signals burst and frame completion to the top-level cartoonifier controller.

Parameters:
- PIX_PER_BURST, 6, pixels per bank; one 32-bit word per pixel.
- TOTAL_PIXELS, 307200, pixels per frame (640x480); must be a multiple of PIX_PER_BURST.
- ADDR_W, 32, Avalon address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-high.
- start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
- base_addr  in  ADDR_W  frame base byte address; sampled on accepted start.
- bank_loaded  in  1  pulse; producer has finished filling the current fill bank.
- fill_bank  out  1  bank the producer must write.
- fill_ready  out  1  fill bank is empty and a frame is active.
- drain_bank  out  1  bank being written out.
- word_sel  out  3  pixel index 0..5 within drain_bank, driving the buffer output mux.
- master_write  out  1  Avalon write strobe.
- master_address  out  ADDR_W  Avalon byte address.
- master_waitrequest  in  1  Avalon stall.
- burst_done  out  1  one-cycle pulse after the 6th word of a bank is accepted.
- frame_done  out  1  one-cycle pulse after the last word of the frame is accepted.
- overflow_err  out  1  sticky; bank_loaded received while fill_ready=0; cleared by accepted start.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; bank_full=2'b00; addr_reg=0; word_idx=0; pix_cnt=0.
- Registers:
  - addr_reg (ADDR_W bits).
  - word_idx (3 bits).
  - pix_cnt (19 bits, sized by $clog2(TOTAL_PIXELS+1)).
  - bank_full[1:0], fill_bank, drain_bank.
- fill_ready = !bank_full[fill_bank] && state is not IDLE or DONE. Combinational.
- IDLE: on start, load addr_reg<=base_addr; clear pix_cnt, bank_full, fill_bank, drain_bank and overflow_err; go to WAIT_BANK.
- WAIT_BANK: master_write=0. If bank_full[drain_bank], set word_idx<=0 and go to WRITE next cycle. Fixed 1-cycle bubble per burst.
- WRITE:
  - master_write=1; master_address=addr_reg; word_sel=word_idx.
  - Address and data are held stable while master_waitrequest=1.
  - A word is accepted when master_write && !master_waitrequest. On acceptance: addr_reg+=4, pix_cnt+=1, word_idx+=1.
  - On accepting word_idx==PIX_PER_BURST-1:
    - clear bank_full[drain_bank]; toggle drain_bank; pulse burst_done.
    - If pix_cnt+1==TOTAL_PIXELS, go to DONE; otherwise go to WAIT_BANK.
- DONE: frame_done=1 for one cycle, then IDLE. master_write=0.
- bank_loaded handling (any state except IDLE/DONE):
  - If fill_ready: set bank_full[fill_bank] and toggle fill_bank.
  - Else: set overflow_err; bank state unchanged.
  - In IDLE/DONE, bank_loaded is ignored and does not set the error.
- Simultaneous events:
  - A bank_loaded set and a drain clear in the same cycle always target different banks; both apply.
  - A drain clearing the current fill bank makes fill_ready rise on the next cycle. No combinational path from waitrequest to fill_ready.
- start outside IDLE is ignored.
- Address wrap: addr_reg wraps modulo 2^ADDR_W with no error.
- Reset mid-burst: all state returns to reset values immediately; master_write drops asynchronously; the partial burst is discarded.

Decomposition:
- Shared package cartoon_pkg:
  - state enum {IDLE, WAIT_BANK, WRITE, DONE}.
  - constants PIX_PER_BURST=6, FRAME_W=640, FRAME_H=480, BYTES_PER_WORD=4.
- One sub-module: bank_tracker, which owns bank_full, fill_bank, drain_bank, fill_ready and overflow_err. Its inputs are bank_loaded and drain_release.
- Address and word counters stay in the top.

Test Plan:
- Reset then start with base_addr=0x1000, TOTAL_PIXELS=12 override, two bank_loaded pulses, waitrequest=0 -> addresses 0x1000..0x102C sequential; word_sel cycles 0..5 twice; burst_done twice; frame_done one cycle after the 12th accept.
- waitrequest held high for 3 cycles on word 2 -> master_address=0x1008 and word_sel=2 stable throughout; exactly one increment after release.
- Two bank_loaded pulses before any drain, then a third while both banks are full -> fill_ready=0 after the 2nd pulse; overflow_err=1 after the 3rd; banks unchanged.
- bank_loaded arriving in the same cycle as the 6th accept of the other bank -> both take effect; WRITE re-entered after exactly 1 WAIT_BANK cycle.
- Assert rst during word 4 of a burst -> master_write=0 immediately; after release, state=IDLE, bank_full=0, and start begins cleanly from the new base_addr.
- Pulse start while in WRITE -> ignored; addr_reg and pix_cnt unaffected.
